// File: rtl/knn_vote_if.sv
// knn_vote_if: sorter-to-voter bus carrying sorted arrays in and classification out
interface knn_vote_if #(
  parameter int N = 64,
  parameter int W = 32,
  parameter int TYPE_W = 3
);
  logic                     valid_sort;
  logic [W*N-1:0]           distance_array_sorted;
  logic [TYPE_W*N-1:0]      type_array_sorted;
  logic                     k_override;
  logic [$clog2(N):0]       k_sel;
  logic [TYPE_W-1:0]        class_out;
  logic [$clog2(N+1)-1:0]   votes_out;
  logic [W-1:0]             nearest_dist;
  logic                     valid_class;
  logic                     busy;
  logic                     dropped;
  modport master (
    output valid_sort, distance_array_sorted, type_array_sorted, k_override, k_sel,
    input  class_out, votes_out, nearest_dist, valid_class, busy, dropped
  );
  modport slave (
    input  valid_sort, distance_array_sorted, type_array_sorted, k_override, k_sel,
    output class_out, votes_out, nearest_dist, valid_class, busy, dropped
  );
endinterface

// File: rtl/knn_vote.sv
// knn_vote: majority vote over the K nearest sorted entries, ties go to the nearest neighbour
module knn_vote #(
  parameter int N = 64,
  parameter int W = 32,
  parameter int TYPE_W = 3,
  parameter int K_DEF = 5
) (
  input logic       clk,
  input logic       rst,
  knn_vote_if.slave bus
);
  localparam int NT = 1 << TYPE_W;
  localparam int CW = $clog2(N + 1);
  localparam int KW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, COUNT, VOTE} state_t;
  state_t state, state_n;
  logic vs_q, vs_rise, last_cnt, last_vote, take;
  logic [TYPE_W*N-1:0] types_q;
  logic [KW-1:0] kraw;
  logic [CW-1:0] k_eff, k_q, idx, best_cnt, best_first;
  logic [CW-1:0] hist [NT];
  logic [CW-1:0] first_idx [NT];
  logic [TYPE_W-1:0] t, j, best;
  assign vs_rise = bus.valid_sort & ~vs_q;
  assign kraw = bus.k_override ? bus.k_sel : KW'(K_DEF);
  assign k_eff = kraw == '0 ? CW'(1) : kraw > KW'(N) ? CW'(N) : CW'(kraw);
  assign t = types_q[idx*TYPE_W +: TYPE_W];
  assign last_cnt = idx == k_q - 1'b1;
  assign last_vote = j == '1;
  assign take = hist[j] > best_cnt || (hist[j] == best_cnt && hist[j] != '0 && first_idx[j] < best_first);
  assign bus.busy = state != IDLE;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // next state: capture, count K entries, then scan every class once
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && vs_rise) ? COUNT :
              (state == COUNT && last_cnt) ? VOTE :
              (state == VOTE && last_vote) ? IDLE : state;
  end
  // capture, histogram build, running best-class scan and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q <= 1'b0;
      types_q <= '0;
      k_q <= '0;
      idx <= '0;
      j <= '0;
      best <= '0;
      best_cnt <= '0;
      best_first <= CW'(N);
      for (int i = 0; i < NT; i++) begin
        hist[i] <= '0;
        first_idx[i] <= CW'(N);
      end
      bus.class_out <= '0;
      bus.votes_out <= '0;
      bus.nearest_dist <= '0;
      bus.valid_class <= 1'b0;
      bus.dropped <= 1'b0;
    end else begin
      vs_q <= bus.valid_sort;
      bus.valid_class <= 1'b0;
      bus.dropped <= vs_rise && state != IDLE;
      if (state == IDLE && vs_rise) begin
        types_q <= bus.type_array_sorted;
        k_q <= k_eff;
        bus.nearest_dist <= bus.distance_array_sorted[W-1:0];
        idx <= '0;
        for (int i = 0; i < NT; i++) begin
          hist[i] <= '0;
          first_idx[i] <= CW'(N);
        end
      end
      if (state == COUNT) begin
        hist[t] <= hist[t] + 1'b1;
        if (first_idx[t] == CW'(N)) first_idx[t] <= idx;
        idx <= idx + 1'b1;
        if (last_cnt) begin
          j <= '0;
          best <= '0;
          best_cnt <= '0;
          best_first <= CW'(N);
        end
      end
      if (state == VOTE) begin
        if (take) begin
          best <= j;
          best_cnt <= hist[j];
          best_first <= first_idx[j];
        end
        j <= j + 1'b1;
        if (last_vote) begin
          bus.class_out <= take ? j : best;
          bus.votes_out <= take ? hist[j] : best_cnt;
          bus.valid_class <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_knn_vote.sv
// tb_knn_vote: directed vectors with hand-computed classifications and latencies
module tb_knn_vote;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int failures = 0;
  int lat, nvalid, ndrop, bcnt;
  logic [63:0] cls, votes;
  knn_vote_if #(.N(64), .W(32), .TYPE_W(3)) bus ();
  knn_vote dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [2:0] v);
    for (int i = 0; i < 64; i++) bus.type_array_sorted[i*3 +: 3] = v;
  endtask

  task automatic set5(input logic [2:0] a, b, c, d, e);
    fill(3'd7);
    bus.type_array_sorted[2:0] = a;
    bus.type_array_sorted[5:3] = b;
    bus.type_array_sorted[8:6] = c;
    bus.type_array_sorted[11:9] = d;
    bus.type_array_sorted[14:12] = e;
  endtask

  // pat bit c is the valid_sort level seen at edge E0+c
  task automatic run(input logic [63:0] pat, input int cycles, input int chg_at, input int rst_at);
    lat = -1; nvalid = 0; ndrop = 0; bcnt = 0;
    for (int c = 0; c < cycles; c++) begin
      bus.valid_sort = c < 64 ? pat[c] : 1'b0;
      rst = c == rst_at;
      if (c == chg_at) begin
        fill(3'd5);
        bus.distance_array_sorted[31:0] = 32'd99;
      end
      @(posedge clk);
      @(negedge clk);
      if (bus.valid_class) begin
        nvalid++;
        if (lat < 0) begin
          lat = c;
          cls = 64'(bus.class_out);
          votes = 64'(bus.votes_out);
        end
      end
      if (bus.dropped) ndrop++;
      if (bus.busy) bcnt++;
    end
    bus.valid_sort = 0;
    rst = 0;
  endtask

  initial begin
    bus.valid_sort = 0;
    bus.k_override = 0;
    bus.k_sel = 7'd9;
    bus.distance_array_sorted = '0;
    bus.distance_array_sorted[31:0] = 32'd100;
    set5(3'd2, 3'd2, 3'd3, 3'd1, 3'd2);
    repeat (3) @(negedge clk);
    check("rst_class", 64'(bus.class_out), 0);
    check("rst_votes", 64'(bus.votes_out), 0);
    check("rst_near", 64'(bus.nearest_dist), 0);
    check("rst_valid", 64'(bus.valid_class), 0);
    check("rst_busy", 64'(bus.busy), 0);
    check("rst_drop", 64'(bus.dropped), 0);
    rst = 0;
    @(negedge clk);
    run(64'h1, 20, -1, -1);
    check("def_lat", 64'(lat), 13);
    check("def_class", cls, 2);
    check("def_votes", votes, 3);
    check("def_nvalid", 64'(nvalid), 1);
    check("def_busy", 64'(bcnt), 13);
    check("def_near", 64'(bus.nearest_dist), 100);
    check("def_hold", 64'(bus.class_out), 2);
    bus.k_override = 1;
    bus.k_sel = 7'd4;
    set5(3'd3, 3'd1, 3'd1, 3'd3, 3'd6);
    run(64'h1, 18, -1, -1);
    check("tie_lat", 64'(lat), 12);
    check("tie_class", cls, 3);
    check("tie_votes", votes, 2);
    set5(3'd1, 3'd3, 3'd3, 3'd1, 3'd6);
    run(64'h1, 18, -1, -1);
    check("tie2_class", cls, 1);
    check("tie2_votes", votes, 2);
    bus.k_sel = 7'd0;
    set5(3'd6, 3'd0, 3'd0, 3'd0, 3'd0);
    run(64'h1, 14, -1, -1);
    check("klo_lat", 64'(lat), 9);
    check("klo_class", cls, 6);
    check("klo_votes", votes, 1);
    bus.k_sel = 7'd100;
    fill(3'd4);
    run(64'h1, 80, -1, -1);
    check("khi_lat", 64'(lat), 72);
    check("khi_class", cls, 4);
    check("khi_votes", votes, 64);
    bus.k_override = 0;
    fill(3'd0);
    run(64'h1, 20, -1, -1);
    check("zero_class", cls, 0);
    check("zero_votes", votes, 5);
    set5(3'd2, 3'd2, 3'd3, 3'd1, 3'd2);
    run(64'h3FFF_FFFF, 40, -1, -1);
    check("lvl_nvalid", 64'(nvalid), 1);
    check("lvl_drop", 64'(ndrop), 0);
    check("lvl_class", cls, 2);
    run(64'h21, 20, -1, -1);
    check("re_drop", 64'(ndrop), 1);
    check("re_nvalid", 64'(nvalid), 1);
    check("re_lat", 64'(lat), 13);
    check("re_class", cls, 2);
    run(64'h1, 20, -1, 3);
    check("abort_nvalid", 64'(nvalid), 0);
    check("abort_class", 64'(bus.class_out), 0);
    check("abort_votes", 64'(bus.votes_out), 0);
    check("abort_near", 64'(bus.nearest_dist), 0);
    check("abort_busy", 64'(bus.busy), 0);
    run(64'h1, 20, -1, -1);
    check("post_lat", 64'(lat), 13);
    check("post_class", cls, 2);
    check("post_votes", votes, 3);
    bus.distance_array_sorted[31:0] = 32'd7;
    run(64'h1, 20, 2, -1);
    check("iso_near", 64'(bus.nearest_dist), 7);
    check("iso_class", cls, 2);
    check("iso_votes", votes, 3);
    set5(3'd2, 3'd2, 3'd3, 3'd1, 3'd2);
    run(64'h4001, 35, -1, -1);
    check("b2b_nvalid", 64'(nvalid), 2);
    check("b2b_drop", 64'(ndrop), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
